mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
//  Issues one data-memory transaction per memory instruction over a req/gnt/rvalid bus.
//  Aligns and sign-extends load data; passes the ALU result and WB control to MEM/WB.
//  Stalls the pipeline while a transaction is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in WAIT_GNT or WAIT_RVALID before abort; range 2..255
// PORTS
//  clk              in   1   clock, rising edge
//  rstN             in   1   asynchronous active-low reset
//  memRead_In       in   1   EX/MEM: load instruction
//  memWrite_In      in   1   EX/MEM: store instruction
//  funct3_In        in   3   EX/MEM: access width/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  aluOut_In        in   32  EX/MEM: address for mem ops, result otherwise
//  storeData_In     in   32  EX/MEM: rs2 value for stores
//  rd_In            in   regName_t  EX/MEM: destination register
//  regWrite_In      in   1   EX/MEM: WB enable
//  memToReg_In      in   1   EX/MEM: WB selects load data
//  dmem_req         out  1   bus request
//  dmem_we          out  1   1=store, 0=load
//  dmem_addr        out  32  word address {aluOut_In[31:2],2'b00}
//  dmem_be          out  4   byte enables
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_gnt         in   1   request accepted
//  dmem_rvalid      in   1   load data valid
//  dmem_rdata       in   32  load data
//  stallMem_Out     out  1   hold PC/IF/ID/EX/MEM registers
//  readD_Out        out  32  aligned, extended load data to MEM/WB
//  aluOut_Out       out  32  aluOut_In passthrough
//  rd_Out           out  regName_t  rd_In passthrough
//  regWrite_Out     out  1   regWrite_In, forced 0 on abort
//  memToReg_Out     out  1   memToReg_In passthrough
//  busErr_Out       out  1   one-cycle pulse on timeout abort
//  misalign_Out     out  1   one-cycle pulse on misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, readD register, timeout counter and all registered outputs 0.
//  dmem_* outputs are 0 while state is not WAIT_GNT.
//  FSM states: IDLE, WAIT_GNT, WAIT_RVALID, DONE.
//   IDLE: non-mem op -> stall=0, stay. Mem op -> stall=1, go to WAIT_GNT.
//    memRead_In & memWrite_In both 1 is treated as a load.
//   WAIT_GNT: dmem_req=1; addr/be/we/wdata held stable.
//    On gnt: store -> DONE, load -> WAIT_RVALID.
//   WAIT_RVALID: req=0. On rvalid, capture aligned rdata -> DONE.
//    rvalid in the same cycle as gnt is illegal; it is ignored.
//   DONE: stall=0 for exactly one cycle -> IDLE. MEM/WB captures readD_Out here.
//  Minimum latency with immediate gnt and rvalid: load 4 cycles, store 3 cycles.
//  Timeout: counter clears on each state entry. Reaching TIMEOUT_CYCLES in WAIT_GNT or
//   WAIT_RVALID -> DONE with busErr_Out=1 and regWrite_Out=0; a later rvalid is ignored.
//  Byte lanes use off=aluOut_In[1:0]:
//   byte  be=1<<off,         wdata={4{sd[7:0]}}
//   half  be=3<<{off[1],1'b0}, wdata={2{sd[15:0]}}
//   word  be=4'hF,           wdata=sd
//  Load extract: select the lane by off, then zero-extend (LBU/LHU) or sign-extend (LB/LH).
//  readD_Out is 0 when the DONE cycle follows a store or an abort.
//  Reset during any state -> IDLE immediately; req drops; the memory shares rstN.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: half with off[0]=1, or word with off!=0:
//   no bus request; IDLE->DONE; misalign_Out=1; regWrite_Out=0.
//  Not defined: low address bits are ignored (half uses off[1], word uses lane 0);
//   misalign_Out is tied 0.
// STRUCTURE
//  definitions package: memFunct3_t enum (LB..LHU, SB..SW), memState_t enum (4 states);
//   regName_t already lives there.
//  Sub-module mem_lane_align (combinational): be/wdata generation, load extract/extend.
// TESTING
//  LW @0x100, gnt and rvalid next cycle, rdata=0xDEADBEEF -> readD=0xDEADBEEF,
//   stall high 3 cycles.
//  LB @0x103, rdata=0x80FFFFFF -> readD=0xFFFFFF80; LBU same -> readD=0x00000080.
//  SH @0x102, sd=0x1234ABCD -> be=4'b1100, wdata=0xABCDABCD, dmem_addr=0x100.
//  gnt withheld 64 cycles -> busErr_Out pulse, regWrite_Out=0, pipeline resumes.
//  rstN low while in WAIT_RVALID -> IDLE, dmem_req=0, stall=0 next cycle.
//  MEM_MISALIGN_TRAP_EN, LW @0x101 -> no dmem_req, misalign_Out=1, regWrite_Out=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: register names,
// memory funct3 encodings and the MEM-stage FSM state type.
package mem_access_stage_pkg;

    typedef logic [4:0] regName_t;

    // Load encodings. Stores reuse the same low bits for their width.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } memFunct3_t;

    localparam memFunct3_t SB = LB;
    localparam memFunct3_t SH = LH;
    localparam memFunct3_t SW = LW;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        DONE        = 2'd3
    } memState_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// mem_lane_align: combinational byte-lane logic for the MEM stage.
// Builds store byte enables and lane-replicated write data, and extracts and
// zero/sign-extends load data from the returned word. Also flags accesses
// whose low address bits do not suit the access width.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    memFunct3_t  f3;
    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign f3 = memFunct3_t'(funct3);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rbyte[off];
    // Halfwords only ever use the upper or lower half; off[0] is ignored.
    assign sel_half = off[1] ? rdata[31:16] : rdata[15:0];

    // Width decode drives enables, write replication and load extension.
    always_comb begin
        be         = 4'hF;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (f3)
            LB, LBU: begin
                be        = 4'b0001 << off;
                wdata     = {4{store_data[7:0]}};
                load_data = (f3 == LB) ? {{24{sel_byte[7]}}, sel_byte}
                                       : {24'b0, sel_byte};
            end
            LH, LHU: begin
                be         = 4'b0011 << {off[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                load_data  = (f3 == LH) ? {{16{sel_half[15]}}, sel_half}
                                        : {16'b0, sel_half};
                misaligned = off[0];
            end
            default: begin
                // Words (and unused encodings) always use all four lanes.
                be         = 4'hF;
                wdata      = store_data;
                load_data  = rdata;
                misaligned = |off;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit between EX/MEM and MEM/WB.
// Issues one req/gnt/rvalid bus transaction per memory instruction, stalls the
// pipeline while it is in flight, and aborts after TIMEOUT_CYCLES without a
// response. Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses skip the bus and raise misalign_Out instead).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        memRead_In,
    input  logic        memWrite_In,
    input  logic [2:0]  funct3_In,
    input  logic [31:0] aluOut_In,
    input  logic [31:0] storeData_In,
    input  regName_t    rd_In,
    input  logic        regWrite_In,
    input  logic        memToReg_In,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stallMem_Out,
    output logic [31:0] readD_Out,
    output logic [31:0] aluOut_Out,
    output regName_t    rd_Out,
    output logic        regWrite_Out,
    output logic        memToReg_Out,
    output logic        busErr_Out,
    output logic        misalign_Out
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    memState_t   state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] readD_reg, readD_next;
    logic        busErr_reg, busErr_next;
    logic        misalign_reg, misalign_next;

    logic        mem_op, is_store, in_gnt, tmo, trap;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;
    logic        lane_misaligned;

    mem_lane_align u_align (
        .funct3     (funct3_In),
        .off        (aluOut_In[1:0]),
        .store_data (storeData_In),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

    // A request with both read and write set is handled as a load.
    assign mem_op   = memRead_In | memWrite_In;
    assign is_store = memWrite_In & ~memRead_In;
    assign in_gnt   = (state_reg == WAIT_GNT);
    assign tmo      = (cnt_reg == 8'(TIMEOUT_CYCLES - 1));
    assign trap     = TRAP_EN & lane_misaligned;

    // Bus outputs are only driven while a request is outstanding.
    assign dmem_req   = in_gnt;
    assign dmem_we    = in_gnt & is_store;
    assign dmem_addr  = in_gnt ? {aluOut_In[31:2], 2'b00} : 32'h0;
    assign dmem_be    = in_gnt ? lane_be : 4'h0;
    assign dmem_wdata = (in_gnt && is_store) ? lane_wdata : 32'h0;

    assign readD_Out    = readD_reg;
    assign aluOut_Out   = aluOut_In;
    assign rd_Out       = rd_In;
    assign memToReg_Out = memToReg_In;
    assign busErr_Out   = busErr_reg;
    assign misalign_Out = misalign_reg;
    // An aborted or trapped access must never write back.
    assign regWrite_Out = regWrite_In & ~(busErr_reg | misalign_reg);

    // State register and registered status/data.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            readD_reg    <= 32'h0;
            busErr_reg   <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            readD_reg    <= readD_next;
            busErr_reg   <= busErr_next;
            misalign_reg <= misalign_next;
        end
    end

    // Next-state, stall and capture logic; response wins over timeout.
    always_comb begin
        state_next    = state_reg;
        readD_next    = readD_reg;
        busErr_next   = 1'b0;
        misalign_next = 1'b0;
        stallMem_Out  = 1'b0;
        cnt_next      = 8'd0;
        case (state_reg)
            IDLE: begin
                readD_next = 32'h0;
                if (mem_op) begin
                    stallMem_Out = 1'b1;
                    if (trap) begin
                        state_next    = DONE;
                        misalign_next = 1'b1;
                    end else begin
                        state_next = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                stallMem_Out = 1'b1;
                if (dmem_gnt) begin
                    state_next = memRead_In ? WAIT_RVALID : DONE;
                end else if (tmo) begin
                    state_next  = DONE;
                    busErr_next = 1'b1;
                end
            end
            WAIT_RVALID: begin
                stallMem_Out = 1'b1;
                if (dmem_rvalid) begin
                    readD_next = lane_load;
                    state_next = DONE;
                end else if (tmo) begin
                    state_next  = DONE;
                    busErr_next = 1'b1;
                end
            end
            DONE: begin
                readD_next = 32'h0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Count cycles spent in a wait state; restart on every state entry.
        if (state_next == state_reg && (state_reg == WAIT_GNT || state_reg == WAIT_RVALID)) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed and randomized transactions
// checked against a per-transaction timeline and lane model.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int T = 64;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic        memRead_In, memWrite_In;
    logic [2:0]  funct3_In;
    logic [31:0] aluOut_In, storeData_In;
    regName_t    rd_In;
    logic        regWrite_In, memToReg_In;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stallMem_Out;
    logic [31:0] readD_Out, aluOut_Out;
    regName_t    rd_Out;
    logic        regWrite_Out, memToReg_Out, busErr_Out, misalign_Out;

    int tests = 0;
    int fails = 0;
    int txn_no = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rstN(rstN),
        .memRead_In(memRead_In), .memWrite_In(memWrite_In), .funct3_In(funct3_In),
        .aluOut_In(aluOut_In), .storeData_In(storeData_In), .rd_In(rd_In),
        .regWrite_In(regWrite_In), .memToReg_In(memToReg_In),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stallMem_Out(stallMem_Out), .readD_Out(readD_Out), .aluOut_Out(aluOut_Out),
        .rd_Out(rd_Out), .regWrite_Out(regWrite_Out), .memToReg_Out(memToReg_Out),
        .busErr_Out(busErr_Out), .misalign_Out(misalign_Out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction through MEM. gd = cycles gnt is withheld, rvd = cycles
    // rvalid is withheld after gnt; values >= T cause a bus timeout.
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdat, input int gd, input int rvd,
                           input bit rw, input bit bogus_rv);
        bit          mem_op, misal, trapped, abort;
        int          nbytes, eoff, gnt_k, rv_k, done_k, last_req_k;
        logic [31:0] exp_be, exp_wd, exp_rd, mask, v;
        regName_t    rd;
        bit          m2r;

        rd  = regName_t'($urandom_range(0, 31));
        m2r = 1'($urandom_range(0, 1));
        mem_op  = ld | st;
        nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        misal   = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'd0);
        trapped = TRAP_EN && mem_op && misal;
        eoff    = (nbytes == 1) ? int'(addr[1:0]) : (nbytes == 2) ? int'(addr[1:0]) & 2 : 0;

        // Lane model: enables cover nbytes starting at eoff; write data repeats
        // the low nbytes of sd across the word.
        exp_be = 32'(((1 << nbytes) - 1) << eoff);
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*(i % nbytes) +: 8];
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
        v = (rdat >> (8*eoff)) & mask;
        if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;

        // Expected timeline, in cycles counted from the issue cycle (k=0).
        gnt_k = -1; rv_k = -1; abort = 1'b0; last_req_k = 0;
        if (!mem_op) begin
            done_k = 0;
        end else if (trapped) begin
            done_k = 1;
        end else if (gd >= T) begin
            abort = 1'b1; last_req_k = T; done_k = 1 + T;
        end else begin
            gnt_k = 1 + gd; last_req_k = gnt_k;
            if (!ld) done_k = gnt_k + 1;
            else if (rvd >= T) begin abort = 1'b1; done_k = gnt_k + 1 + T; end
            else begin rv_k = gnt_k + 1 + rvd; done_k = rv_k + 1; end
        end
        exp_rd = (ld && mem_op && !abort && !trapped) ? v : 32'h0;

        for (int k = 0; k <= done_k; k++) begin
            step();
            memRead_In = ld; memWrite_In = st; funct3_In = f3;
            aluOut_In = addr; storeData_In = sd; rd_In = rd;
            regWrite_In = rw; memToReg_In = m2r;
            dmem_gnt    = (k == gnt_k);
            dmem_rvalid = (k == rv_k) || (bogus_rv && ld && k == gnt_k);
            dmem_rdata  = (k == rv_k) ? rdat : $urandom;
            #1;
            check("stall", 32'(stallMem_Out), 32'(k < done_k));
            check("req", 32'(dmem_req), 32'(mem_op && !trapped && k >= 1 && k <= last_req_k));
            if (mem_op && !trapped && k == 1) begin
                check("addr", dmem_addr, {addr[31:2], 2'b00});
                check("be", 32'(dmem_be), exp_be);
                check("we", 32'(dmem_we), 32'(st && !ld));
                if (st && !ld) check("wdata", dmem_wdata, exp_wd);
            end
            if (k == done_k) begin
                check("aluOut", aluOut_Out, addr);
                check("regWrite", 32'(regWrite_Out), 32'(rw && !abort && !trapped));
                check("busErr", 32'(busErr_Out), 32'(abort));
                check("misalign", 32'(misalign_Out), 32'(trapped));
                if (mem_op) begin
                    check("readD", readD_Out, exp_rd);
                    check("rd", 32'(rd_Out), 32'(rd));
                    check("memToReg", 32'(memToReg_Out), 32'(m2r));
                end
            end
        end
        $display("[TB] txn %0d ld=%0b st=%0b f3=%0d addr=0x%08h gd=%0d rvd=%0d done@%0d readD=0x%08h",
                 txn_no, ld, st, f3, addr, gd, rvd, done_k, readD_Out);
        txn_no++;
        memRead_In = 1'b0; memWrite_In = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        // A response arriving after a read timeout must not restart anything.
        if (ld && abort && gd < T) begin
            step();
            dmem_rvalid = 1'b1; dmem_rdata = $urandom;
            #1;
            check("late_rv_stall", 32'(stallMem_Out), 32'h0);
            check("late_rv_busErr", 32'(busErr_Out), 32'h0);
            dmem_rvalid = 1'b0;
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        int kind, gd, rvd;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rstN = 1'b0;
        memRead_In = 0; memWrite_In = 0; funct3_In = 0; aluOut_In = 0; storeData_In = 0;
        rd_In = '0; regWrite_In = 0; memToReg_In = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        step(); step();
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_stall", 32'(stallMem_Out), 32'h0);
        check("rst_readD", readD_Out, 32'h0);
        check("rst_busErr", 32'(busErr_Out), 32'h0);
        check("rst_misalign", 32'(misalign_Out), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        rstN = 1'b1;

        // Directed cases
        run_txn(1, 0, LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1, 0);
        run_txn(1, 0, LB,  32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 1, 0);
        run_txn(1, 0, LBU, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 1, 0);
        run_txn(0, 1, SH,  32'h102, 32'h1234ABCD, 32'h0, 0, 0, 0, 0);
        run_txn(0, 1, SB,  32'h201, 32'hCAFE00A5, 32'h0, 2, 0, 0, 0);
        run_txn(0, 1, SW,  32'h300, 32'h89ABCDEF, 32'h0, 1, 0, 0, 0);
        run_txn(1, 0, LH,  32'h402, 32'h0, 32'h8001_7FFF, 1, 2, 1, 1);
        run_txn(1, 1, LHU, 32'h500, 32'h0, 32'h1234_F00D, 0, 1, 1, 0);
        run_txn(0, 0, LW,  32'h1357_9BDF, 32'h0, 32'h0, 0, 0, 1, 0);
        run_txn(1, 0, LW,  32'h600, 32'h0, 32'h0BAD_F00D, T-1, 0, 1, 0);
        run_txn(1, 0, LW,  32'h700, 32'h0, 32'h0, T, 0, 1, 0);
        run_txn(1, 0, LW,  32'h800, 32'h0, 32'h0, 0, T, 1, 0);
        run_txn(1, 0, LW,  32'h101, 32'h0, 32'h11223344, 0, 0, 1, 0);
        run_txn(0, 1, SH,  32'h103, 32'hAAAA5555, 32'h0, 0, 0, 1, 0);

        // Reset while waiting for read data
        step();
        memRead_In = 1; funct3_In = LW; aluOut_In = 32'h200; regWrite_In = 1;
        step();
        dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        #1;
        check("rvwait_req", 32'(dmem_req), 32'h0);
        check("rvwait_stall", 32'(stallMem_Out), 32'h1);
        rstN = 1'b0; memRead_In = 0;
        #1;
        check("midrst_req", 32'(dmem_req), 32'h0);
        check("midrst_stall", 32'(stallMem_Out), 32'h0);
        check("midrst_readD", readD_Out, 32'h0);
        step();
        rstN = 1'b1;
        step();
        #1;
        check("postrst_stall", 32'(stallMem_Out), 32'h0);
        check("postrst_req", 32'(dmem_req), 32'h0);
        run_txn(1, 0, LW, 32'h240, 32'h0, 32'h5A5A_1234, 0, 0, 1, 0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            gd  = ($urandom_range(0, 14) == 0) ? T : $urandom_range(0, 3);
            rvd = ($urandom_range(0, 14) == 0) ? T : $urandom_range(0, 3);
            if (kind < 2)
                run_txn(0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 0, 0,
                        1'($urandom_range(0, 1)), 0);
            else if (kind < 6)
                run_txn(1, 0, ld_f3[$urandom_range(0, 4)], $urandom, $urandom, $urandom, gd, rvd,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (kind < 9)
                run_txn(0, 1, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom, gd, rvd,
                        1'($urandom_range(0, 1)), 0);
            else
                run_txn(1, 1, ld_f3[$urandom_range(0, 4)], $urandom, $urandom, $urandom, gd, rvd,
                        1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
